pixel_word_packer: RTL and testbench
====================================

PIXEL_WORD_PACKER -- requirements
Module: pixel_word_packer

Interface
REQ-001 SHALL have parameter IN_W, default 32: width in bits of one input word per channel.
REQ-002 SHALL have parameter RATIO, default 4: input words per packed output word; legal values 2..16.
REQ-003 SHALL have parameter NCH, default 2: channels packed in lock-step, e.g. background and foreground.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port aresetn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port in_data, input, NCH*IN_W: channel c occupies bits [c*IN_W +: IN_W].
REQ-007 SHALL have port in_valid, input, 1: in_data holds a beat for all channels.
REQ-008 SHALL have port in_ready, output, 1: the block accepts the beat this cycle.
REQ-009 SHALL have port out_data, output, NCH*IN_W*RATIO: channel c occupies bits [c*IN_W*RATIO +: IN_W*RATIO].
REQ-010 SHALL have port out_valid, output, 1: out_data holds a packed word.
REQ-011 SHALL have port out_ready, input, 1: sink accepts the word; driven from ~fifo_full.
REQ-012 SHALL have port out_beats, output, $clog2(RATIO)+1: number of valid lanes in out_data.

Function
REQ-013 SHALL transfer a beat when in_valid && in_ready, and a word when out_valid && out_ready, both sampled at the clk rising edge.
REQ-014 SHALL place the k-th accepted beat of a word, k = 0..RATIO-1, in lane bits [k*IN_W +: IN_W] of each channel, so the first beat lands in the LSBs.
REQ-015 SHALL keep a beat counter 0..RATIO-1 that increments on each accepted beat and wraps to 0 on the beat that completes a word.
REQ-016 SHALL load the output register with the accumulated lanes plus the completing beat on the clock edge that accepts beat RATIO-1, and set out_valid=1 and out_beats=RATIO.
REQ-017 SHALL give a latency of 1 cycle from acceptance of the last beat to out_valid=1.
REQ-018 SHALL drive in_ready = (beat_cnt != RATIO-1) || !out_valid || out_ready, with no combinational path from in_valid.
REQ-019 SHALL sustain one beat per cycle while out_ready=1, so a packed word is produced every RATIO cycles.
REQ-020 SHALL hold out_data and out_beats stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid after a transfer unless a new word is loaded on the same edge, in which case out_valid stays 1.
REQ-022 SHALL zero the lanes of the accumulation register at or above the current beat index whenever it starts a new word.
REQ-023 SHALL treat all channels identically and never allow their beat positions to diverge.

Reset
REQ-024 SHALL, while aresetn=0, asynchronously force out_valid=0, out_beats=0, out_data=0, beat_cnt=0, accumulation register=0 and flush_pend=0; in_ready is then 1.
REQ-025 SHALL discard any partially packed word when reset is asserted mid-word, and start the first word after reset release at lane 0.

Configuration
REQ-026 SHALL, with PIXEL_PACKER_FLUSH_EN defined, add input port flush (1 bit), a single-cycle request that is latched into flush_pend.
REQ-027 SHALL, with PIXEL_PACKER_FLUSH_EN defined and flush_pend=1, emit the partial word (unfilled lanes zero, out_beats=beat_cnt) on the first edge the output register is free or draining, then reset beat_cnt to 0 and clear flush_pend.
REQ-028 SHALL include the beat in the emitted word, with out_beats=beat_cnt+1, when flush coincides with an accepted beat.
REQ-029 SHALL clear flush_pend with no output when flush_pend=1 and beat_cnt=0.
REQ-030 SHALL deassert in_ready while flush_pend=1 and the partial word has not yet been emitted.
REQ-031 SHALL, without PIXEL_PACKER_FLUSH_EN, have no flush port, and out_beats SHALL always equal RATIO when out_valid=1.

Structure
REQ-032 SHALL place the default values of IN_W, RATIO and NCH, and a beat-count width function, in shared package pixel_packer_pkg.
REQ-033 SHALL instantiate sub-module packer_lane once per channel: lane accumulator and output register for one channel, all instances driven by a shared beat/control FSM.

Verification
REQ-034 SHALL test: defaults, beats 0x11111111..0x44444444 on ch0 and 0xA..0xD on ch1, out_ready=1 -> one cycle after beat 4, out ch0=0x44444444_33333333_22222222_11111111, out_beats=4.
REQ-035 SHALL test: 8 back-to-back beats with out_ready=1 -> in_ready stays 1 and out_valid pulses at cycles 5 and 9.
REQ-036 SHALL test: out_ready=0 with a word pending and 3 more beats sent -> 4th beat stalls with in_ready=0 until out_ready=1, and out_data holds.
REQ-037 SHALL test: aresetn pulled low after 2 beats -> outputs 0 immediately; the next 4 beats pack starting at lane 0.
REQ-038 SHALL test, with PIXEL_PACKER_FLUSH_EN: 3 beats then flush -> out_beats=3 with the top lane 0; flush at beat_cnt=0 -> no output.

Source files
------------

// File: rtl/pixel_packer_pkg.sv
// Shared defaults, load-kind encoding and width helpers for the pixel word packer.
// Pure declarations: no logic, no latency, no flow control.
package pixel_packer_pkg;

    localparam int DEF_IN_W  = 32;
    localparam int DEF_RATIO = 4;
    localparam int DEF_NCH   = 2;

    // What the output register does on the coming edge.
    typedef enum logic [1:0] {
        LD_NONE  = 2'd0,
        LD_FULL  = 2'd1,
        LD_FLUSH = 2'd2,
        LD_DROP  = 2'd3
    } load_e;

    // Width of out_beats: must hold the value RATIO itself.
    function automatic int beat_cnt_w(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

    // Width of the lane index 0..RATIO-1.
    function automatic int lane_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/packer_lane.sv
// One channel of the packer: lane accumulator plus packed output register.
// Latency: output register loads on the edge the controller asks for; no own backpressure.
// Backpressure: none locally, write/load/clear strobes come from the shared controller.
module packer_lane
    import pixel_packer_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int RATIO = DEF_RATIO,
    parameter int CW    = lane_idx_w(DEF_RATIO)
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [IN_W-1:0]       in_dat,
    input  logic                  wr_en,
    input  logic [CW-1:0]         wr_idx,
    input  logic                  load_out,
    input  logic                  acc_clr,
    output logic [IN_W*RATIO-1:0] out_dat
);

    localparam int WW = IN_W * RATIO;

    logic [WW-1:0] acc_q;
    logic [WW-1:0] acc_d;
    logic [WW-1:0] acc_wr;
    logic [WW-1:0] word_q;
    logic [WW-1:0] word_d;

    always_comb begin
        acc_wr = acc_q;
        for (int k = 0; k < RATIO; k++) begin
            if (wr_en && (wr_idx == CW'(k))) begin
                acc_wr[k*IN_W +: IN_W] = in_dat;
            end
        end
        // The completing beat is folded in before the word is captured.
        word_d = load_out ? acc_wr : word_q;
        // Clearing on every word start keeps the not-yet-written lanes at zero.
        acc_d  = acc_clr ? '0 : acc_wr;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q  <= '0;
            word_q <= '0;
        end else begin
            acc_q  <= acc_d;
            word_q <= word_d;
        end
    end

    assign out_dat = word_q;

endmodule

// File: rtl/pixel_word_packer.sv
// Packs RATIO narrow beats per channel into one wide word, NCH channels in lock-step.
// Latency: 1 cycle from the completing beat to out_valid; one beat per cycle sustained.
// Backpressure: in_ready drops only when the last lane is due and the output is stalled.
// Optional partial-word flush port enabled by macro PIXEL_PACKER_FLUSH_EN.
module pixel_word_packer
    import pixel_packer_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int RATIO = DEF_RATIO,
    parameter int NCH   = DEF_NCH
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic [NCH*IN_W-1:0]       in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NCH*IN_W*RATIO-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef PIXEL_PACKER_FLUSH_EN
    input  logic                      flush,
`endif
    output logic [$clog2(RATIO):0]    out_beats
);

    localparam int            CW       = lane_idx_w(RATIO);
    localparam int            BW       = beat_cnt_w(RATIO);
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    logic [CW-1:0] beat_cnt_q;
    logic [CW-1:0] beat_cnt_d;
    logic          out_valid_q;
    logic          out_valid_d;
    logic [BW-1:0] out_beats_q;
    logic [BW-1:0] out_beats_d;
    logic          flush_pend_q;
    logic          flush_pend_d;

    logic          flush_req;
    logic          out_free;
    logic          beat_acc;
    logic          lane_load;
    load_e         ld_kind;

`ifdef PIXEL_PACKER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    always_comb begin
        out_free = !out_valid_q || out_ready;
        // A pending flush blocks new beats until the partial word has left.
        in_ready = ((beat_cnt_q != LAST_IDX) || out_free) && !flush_pend_q;
        beat_acc = in_valid && in_ready;

        ld_kind = LD_NONE;
        if (beat_acc && (beat_cnt_q == LAST_IDX)) begin
            ld_kind = LD_FULL;
        end else if (flush_pend_q && (beat_cnt_q == '0)) begin
            ld_kind = LD_DROP;
        end else if (flush_pend_q && out_free) begin
            ld_kind = LD_FLUSH;
        end

        lane_load = (ld_kind == LD_FULL) || (ld_kind == LD_FLUSH);

        beat_cnt_d = beat_cnt_q;
        if (lane_load) begin
            beat_cnt_d = '0;
        end else if (beat_acc) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end

        out_valid_d = out_valid_q;
        out_beats_d = out_beats_q;
        if (lane_load) begin
            out_valid_d = 1'b1;
            out_beats_d = (ld_kind == LD_FULL) ? BW'(RATIO) : BW'(beat_cnt_q);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        flush_pend_d = flush_pend_q;
        if ((ld_kind == LD_FLUSH) || (ld_kind == LD_DROP)) begin
            flush_pend_d = 1'b0;
        end
        if (flush_req) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_beats_q  <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            out_valid_q  <= out_valid_d;
            out_beats_q  <= out_beats_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Every channel shares the same beat index and strobes, so lanes never diverge.
    for (genvar c = 0; c < NCH; c++) begin : g_lane
        packer_lane #(
            .IN_W  (IN_W),
            .RATIO (RATIO),
            .CW    (CW)
        ) u_lane (
            .clk      (clk),
            .aresetn  (aresetn),
            .in_dat   (in_data[c*IN_W +: IN_W]),
            .wr_en    (beat_acc),
            .wr_idx   (beat_cnt_q),
            .load_out (lane_load),
            .acc_clr  (lane_load),
            .out_dat  (out_data[c*IN_W*RATIO +: IN_W*RATIO])
        );
    end

    assign out_valid = out_valid_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed bench for pixel_word_packer at default parameters; flush cases when PIXEL_PACKER_FLUSH_EN is set.
module tb_pixel_word_packer;

    localparam int IN_W  = 32;
    localparam int RATIO = 4;
    localparam int NCH   = 2;

    logic                      clk     = 1'b0;
    logic                      aresetn = 1'b1;
    logic [NCH*IN_W-1:0]       in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [NCH*IN_W*RATIO-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [$clog2(RATIO):0]    out_beats;
`ifdef PIXEL_PACKER_FLUSH_EN
    logic                      flush;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pixel_word_packer #(
        .IN_W  (IN_W),
        .RATIO (RATIO),
        .NCH   (NCH)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIXEL_PACKER_FLUSH_EN
        .flush     (flush),
`endif
        .out_beats (out_beats)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef PIXEL_PACKER_FLUSH_EN
        flush     = 1'b0;
`endif
        #2 aresetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_beats", out_beats, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_in_ready",  in_ready,  1);
        aresetn = 1'b1;
        tick();

        // Basic packing: first beat must land in the LSB lane.
        send_beat({32'h0000000A, 32'h11111111});
        send_beat({32'h0000000B, 32'h22222222});
        send_beat({32'h0000000C, 32'h33333333});
        send_beat({32'h0000000D, 32'h44444444});
        check("t1_out_valid", out_valid, 1);
        check("t1_ch0", out_data[127:0],   128'h44444444_33333333_22222222_11111111);
        check("t1_ch1", out_data[255:128], 128'h0000000D_0000000C_0000000B_0000000A);
        check("t1_out_beats", out_beats, 4);
        tick();
        check("t1_valid_clears", out_valid, 0);

        // Eight back-to-back beats: out_valid only in cycles 5 and 9.
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8);
            in_data  = {32'(32'hB0000000 + i), 32'(32'h00000100 + i)};
            check($sformatf("t2_in_ready_c%0d", i + 1), in_ready, 1);
            check($sformatf("t2_out_valid_c%0d", i + 1), out_valid, (i == 4 || i == 8));
            if (i == 4) check("t2_word1", out_data,
                {128'hB0000003_B0000002_B0000001_B0000000, 128'h00000103_00000102_00000101_00000100});
            if (i == 8) check("t2_word2", out_data,
                {128'hB0000007_B0000006_B0000005_B0000004, 128'h00000107_00000106_00000105_00000104});
            tick();
        end
        in_valid = 1'b0;

        // Stalled sink: word A pending, three beats absorbed, fourth must wait.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_beat({32'(32'h20000000 + k), 32'(32'h10000000 + k)});
        check("t3_a_valid", out_valid, 1);
        for (int k = 0; k < 3; k++) send_beat({32'(32'h40000000 + k), 32'(32'h30000000 + k)});
        in_valid = 1'b1;
        in_data  = {32'h40000003, 32'h30000003};
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t3_stall_in_ready_%0d", k), in_ready, 0);
            check($sformatf("t3_hold_data_%0d", k), out_data,
                {128'h20000003_20000002_20000001_20000000, 128'h10000003_10000002_10000001_10000000});
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("t3_release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("t3_b_valid", out_valid, 1);
        check("t3_b_data", out_data,
            {128'h40000003_40000002_40000001_40000000, 128'h30000003_30000002_30000001_30000000});
        tick();
        check("t3_b_drained", out_valid, 0);

        // Reset mid-word: outputs clear at once, partial word discarded.
        send_beat({32'hDEAD0001, 32'hBEEF0001});
        send_beat({32'hDEAD0002, 32'hBEEF0002});
        aresetn = 1'b0;
        #1;
        check("t4_rst_out_data",  out_data,  0);
        check("t4_rst_out_valid", out_valid, 0);
        check("t4_rst_out_beats", out_beats, 0);
        check("t4_rst_in_ready",  in_ready,  1);
        tick();
        aresetn = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) send_beat({32'(32'h60000000 + k), 32'(32'h50000000 + k)});
        check("t4_valid", out_valid, 1);
        check("t4_word", out_data,
            {128'h60000003_60000002_60000001_60000000, 128'h50000003_50000002_50000001_50000000});
        check("t4_out_beats", out_beats, 4);
        tick();

`ifdef PIXEL_PACKER_FLUSH_EN
        // Flush after three beats: partial word, top lane zero.
        for (int k = 0; k < 3; k++) send_beat({32'(32'h80000000 + k), 32'(32'h70000000 + k)});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_pend_in_ready", in_ready, 0);
        check("t5_pend_no_valid", out_valid, 0);
        tick();
        check("t5_flush_valid", out_valid, 1);
        check("t5_flush_beats", out_beats, 3);
        check("t5_flush_data", out_data,
            {128'h00000000_80000002_80000001_80000000, 128'h00000000_70000002_70000001_70000000});
        tick();
        check("t5_flush_drained", out_valid, 0);
        // Flush with nothing buffered produces no word.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t5_empty_flush_%0d", k), out_valid, 0);
            tick();
        end
        check("t5_empty_in_ready", in_ready, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
